// File: rtl/valid_stream_fifo_pkg.sv
// Shared defaults for the valid-only to valid/ready stream FIFO.
// The package holds only default sizes; every width is derived locally from width and depth.
package valid_stream_fifo_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;
endpackage

// File: rtl/valid_stream_fifo_storage.sv
// Register-array storage for the stream FIFO.
// Provides one synchronous write port and one combinational read port; the contents are never reset.
module fifo_storage #(
    parameter int width = 8,
    parameter int depth = 8,
    localparam int AW = $clog2(depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/valid_stream_fifo.sv
// Converts a valid-only stream into a first-word-fall-through valid/ready stream.
// The FIFO has no backpressure to upstream; an input that arrives while the FIFO is full is dropped and flagged.
module valid_stream_fifo
    import valid_stream_fifo_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int depth = DEF_DEPTH,
    localparam int AW = $clog2(depth),
    localparam int PW = AW + 1,
    localparam int CW = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [width-1:0] in_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [width-1:0] out_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] ptr_diff;
    logic          push;
    logic          pop;
    logic          drop;

    // Pointers carry one extra wrap bit, so full and empty are told apart without a separate count register.
    assign ptr_diff = wr_ptr - rd_ptr;
    assign count    = CW'(ptr_diff);
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_vld  = !empty;

    assign pop  = out_vld && out_rdy;
    assign push = in_vld && (!full || pop);
    assign drop = in_vld && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // On a push while full, the write lands in the slot whose old value is being popped at the same edge.
    fifo_storage #(
        .width (width),
        .depth (depth)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_valid_stream_fifo.sv
// Directed testbench for valid_stream_fifo (width=8, depth=8).
// Checks reset, FWFT latency, fill, full with concurrent push and pop, overflow, pointer wrap, and asynchronous reset.
module tb_valid_stream_fifo;

    logic       clk;
    logic       rst;
    logic       in_vld;
    logic [7:0] in_data;
    logic       out_vld;
    logic       out_rdy;
    logic [7:0] out_data;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    valid_stream_fifo #(
        .width (8),
        .depth (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_q [8];

        rst     = 1'b0;
        in_vld  = 1'b0;
        in_data = 8'h00;
        out_rdy = 1'b0;
        step();
        step();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_vld", out_vld, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);

        // The push is accepted at the first edge after reset is released.
        rst     = 1'b1;
        in_vld  = 1'b1;
        in_data = 8'hA5;
        step();
        in_vld  = 1'b0;
        chk("single_vld", out_vld, 1);
        chk("single_data", out_data, 8'hA5);
        chk("single_count", count, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_vld", out_vld, 1);
            chk("hold_data", out_data, 8'hA5);
        end
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        chk("single_pop_empty", empty, 1);

        // Fill with the values 1 through 8.
        for (int i = 1; i <= 8; i++) begin
            in_vld  = 1'b1;
            in_data = 8'(i);
            step();
            chk("fill_count", count, i);
        end
        in_vld = 1'b0;
        chk("fill_full", full, 1);
        chk("fill_head", out_data, 8'h01);

        // While full, push 99 and pop at the same edge.
        in_vld  = 1'b1;
        in_data = 8'h99;
        out_rdy = 1'b1;
        step();
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        chk("pp_count", count, 8);
        chk("pp_full", full, 1);
        chk("pp_ovf", overflow, 0);
        chk("pp_head", out_data, 8'h02);

        // While full with no pop, the value 55 is dropped.
        in_vld  = 1'b1;
        in_data = 8'h55;
        step();
        in_vld  = 1'b0;
        chk("ovf_count", count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", out_data, 8'h02);

        exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h99};
        out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("drain_vld", out_vld, 1);
            chk("drain_data", out_data, exp_q[k]);
            step();
        end
        out_rdy = 1'b0;
        chk("drain_empty", empty, 1);
        chk("drain_ovf", overflow, 1);

        // Pointer wrap test: each value passes straight through one cycle after its push.
        out_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_vld  = 1'b1;
            in_data = 8'(8'h20 + i);
            step();
            chk("wrap_vld", out_vld, 1);
            chk("wrap_data", out_data, 8'(8'h20 + i));
            chk("wrap_count", count, 1);
        end
        in_vld = 1'b0;
        step();
        out_rdy = 1'b0;
        chk("wrap_empty", empty, 1);

        // Mid-operation reset is asserted between clock edges.
        for (int i = 0; i < 3; i++) begin
            in_vld  = 1'b1;
            in_data = 8'(8'h30 + i);
            step();
        end
        in_vld = 1'b0;
        chk("pre_rst_count", count, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("async_vld", out_vld, 0);
        chk("async_count", count, 0);
        chk("async_empty", empty, 1);
        chk("async_ovf", overflow, 0);
        step();
        rst     = 1'b1;
        in_vld  = 1'b1;
        in_data = 8'h11;
        step();
        in_vld  = 1'b0;
        chk("post_rst_vld", out_vld, 1);
        chk("post_rst_data", out_data, 8'h11);
        chk("post_rst_count", count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
